// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive controller
package uart_rx_pkg;
   localparam int DATA_WIDTH = 8;
   localparam logic [3:0] START_BIT = 4'd0;
   localparam logic [3:0] LAST_DATA_BIT = 4'd8;
   localparam logic [3:0] PARITY_BIT = 4'd9;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/uart_rx_ctrl_data_sampler.sv
// data_sampler: 2-of-3 majority vote of rx_in around the middle of each bit
module data_sampler (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] prescale,
   input  logic [5:0] edge_cnt,
   input  logic       rx_in,
   input  logic       enable,
   output logic       sampled_bit
);
   logic [5:0] mid;
   logic [1:0] s;
   assign mid = prescale >> 1;
   always_ff @(posedge CLK) begin
      if (!RST) begin
         s <= '0;
         sampled_bit <= 1'b0;
      end else if (enable) begin
         if (edge_cnt == mid - 6'd1) s[0] <= rx_in;
         if (edge_cnt == mid) s[1] <= rx_in;
         if (edge_cnt == mid + 6'd1) sampled_bit <= (s[0] & s[1]) | (s[0] & rx_in) | (s[1] & rx_in);
      end
   end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM sequencing edge_bit_counter, shifting and checking frames
module uart_rx_ctrl
   import uart_rx_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rx_in,
   input  logic [5:0]            prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [3:0]            bit_cnt,
   input  logic [5:0]            edge_cnt,
   output logic                  cnt_enable,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);
   state_e state, state_d;
   logic [DATA_WIDTH-1:0] shift, shift_d, p_data_d;
   logic pe_q, pe_d, pt_q, pt_d, dv_d, par_err_d, stp_err_d;
   logic sampled, eob;

   assign cnt_enable = state != IDLE;
   assign eob = edge_cnt == prescale - 6'd1;

   data_sampler u_sampler (
      .CLK(CLK),
      .RST(RST),
      .prescale(prescale),
      .edge_cnt(edge_cnt),
      .rx_in(rx_in),
      .enable(cnt_enable),
      .sampled_bit(sampled)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
         shift <= '0;
         p_data <= '0;
         data_valid <= 1'b0;
         par_err <= 1'b0;
         stp_err <= 1'b0;
         pe_q <= 1'b0;
         pt_q <= 1'b0;
      end else begin
         state <= state_d;
         shift <= shift_d;
         p_data <= p_data_d;
         data_valid <= dv_d;
         par_err <= par_err_d;
         stp_err <= stp_err_d;
         pe_q <= pe_d;
         pt_q <= pt_d;
      end
   end

   always_comb begin
      state_d = state;
      shift_d = shift;
      p_data_d = p_data;
      dv_d = 1'b0;
      par_err_d = par_err;
      stp_err_d = stp_err;
      pe_d = pe_q;
      pt_d = pt_q;
      case (state)
         IDLE: if (!rx_in) begin
            state_d = START;
            pe_d = par_en;
            pt_d = par_typ;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
         end
         START: if (eob) state_d = sampled ? IDLE : DATA;
         DATA: if (eob) begin
            shift_d = {sampled, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_DATA_BIT) state_d = pe_q ? PARITY : STOP;
         end
         PARITY: if (eob) begin
            par_err_d = (^shift ^ sampled) != pt_q;
            state_d = STOP;
         end
         STOP: if (eob) begin
            stp_err_d = ~sampled;
            // a frame is delivered only when both the stop bit and parity are good
            if (sampled && !par_err) begin
               p_data_d = shift;
               dv_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table, directed and random frames against a frame-level model
module tb_uart_rx_ctrl;
   logic CLK = 0, RST = 0, rx_in = 1, par_en = 0, par_typ = 0;
   logic [5:0] prescale = 6'd8;
   logic [3:0] bit_cnt;
   logic [5:0] edge_cnt;
   logic cnt_enable, data_valid, par_err, stp_err;
   logic [7:0] p_data;
   int total = 0, bad = 0, cyc = 0, dv_cnt = 0, last_dv_cyc = -1;
   logic [7:0] dv_q[$];
   logic [7:0] model_pd = 8'h00;

   typedef struct {
      logic [5:0] p;
      logic pe, pt;
      logic [7:0] d;
      logic flip, sb;
      logic e_dv;
      logic [7:0] e_pd;
      logic e_pe, e_se;
   } vec_t;
   vec_t vt[6];

   uart_rx_ctrl dut (
      .CLK(CLK), .RST(RST), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
      .par_typ(par_typ), .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .cnt_enable(cnt_enable),
      .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // stand-in for the neighbouring edge_bit_counter
   always @(posedge CLK) begin
      if (!RST || !cnt_enable) begin
         edge_cnt <= 6'd0;
         bit_cnt <= 4'd0;
      end else if (edge_cnt == prescale - 6'd1) begin
         edge_cnt <= 6'd0;
         bit_cnt <= bit_cnt + 4'd1;
      end else edge_cnt <= edge_cnt + 6'd1;
   end

   always @(posedge CLK) begin
      #1;
      if (data_valid) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         dv_q.push_back(p_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [5:0] p, input logic pe, input logic pt, input logic [7:0] d,
                       input logic flip, input logic sb, output int t0);
      logic [10:0] bits;
      int n;
      n = pe ? 11 : 10;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (pe) bits[9] = ^d ^ pt ^ flip;
      bits[n-1] = sb;
      prescale = p;
      par_en = pe;
      par_typ = pt;
      t0 = cyc + 1;
      for (int i = 0; i < n; i++) begin
         rx_in = bits[i];
         repeat (int'(p)) @(negedge CLK);
      end
      rx_in = 1'b1;
   endtask

   task automatic frame(input string nm, input logic [5:0] p, input logic pe, input logic pt,
                        input logic [7:0] d, input logic flip, input logic sb, input logic e_dv,
                        input logic [7:0] e_pd, input logic e_pe, input logic e_se);
      int t0, c0, n;
      c0 = dv_cnt;
      n = pe ? 11 : 10;
      send(p, pe, pt, d, flip, sb, t0);
      @(negedge CLK);
      chk({nm, "_dv"}, data_valid, e_dv);
      chk({nm, "_pdata"}, p_data, e_pd);
      chk({nm, "_parerr"}, par_err, e_pe);
      chk({nm, "_stperr"}, stp_err, e_se);
      if (e_dv) chk({nm, "_dvcyc"}, last_dv_cyc, t0 + n * int'(p));
      repeat (3) @(negedge CLK);
      chk({nm, "_dvcount"}, dv_cnt - c0, e_dv);
      chk({nm, "_idle"}, cnt_enable, 0);
   endtask

   initial begin
      int t0, t1, c0;
      logic [5:0] rp;
      logic rpe, rpt, rfl, rsb, edv, epe, ese;
      logic [7:0] rd;
      vt[0] = '{6'd8,  0, 0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0};
      vt[1] = '{6'd16, 1, 1, 8'h3C, 0, 1, 1, 8'h3C, 0, 0};
      vt[2] = '{6'd16, 1, 1, 8'h3C, 1, 1, 0, 8'h3C, 1, 0};
      vt[3] = '{6'd8,  0, 0, 8'h5A, 0, 0, 0, 8'h3C, 0, 1};
      vt[4] = '{6'd32, 1, 0, 8'h81, 0, 1, 1, 8'h81, 0, 0};
      vt[5] = '{6'd8,  1, 0, 8'h00, 1, 0, 0, 8'h81, 1, 1};

      repeat (3) @(negedge CLK);
      chk("rst_pdata", p_data, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_errs", {par_err, stp_err}, 0);
      chk("rst_cnten", cnt_enable, 0);
      RST = 1;
      repeat (2) @(negedge CLK);

      foreach (vt[i])
         frame($sformatf("vec%0d", i), vt[i].p, vt[i].pe, vt[i].pt, vt[i].d, vt[i].flip, vt[i].sb,
               vt[i].e_dv, vt[i].e_pd, vt[i].e_pe, vt[i].e_se);
      model_pd = 8'h81;

      // start glitch shorter than the mid-bit window
      prescale = 6'd16;
      c0 = dv_cnt;
      rx_in = 1'b0;
      repeat (2) @(negedge CLK);
      rx_in = 1'b1;
      repeat (14) @(negedge CLK);
      chk("glitch_start_held", cnt_enable, 1);
      @(negedge CLK);
      chk("glitch_idle", cnt_enable, 0);
      chk("glitch_errs", {par_err, stp_err}, 0);
      repeat (2) @(negedge CLK);
      chk("glitch_nodv", dv_cnt - c0, 0);
      frame("after_glitch", 6'd16, 0, 0, 8'h55, 0, 1, 1, 8'h55, 0, 0);

      // reset in the middle of the data bits
      c0 = dv_cnt;
      fork
         send(6'd8, 0, 0, 8'hFF, 0, 1, t0);
         begin
            repeat (40) @(negedge CLK);
            RST = 0;
            @(negedge CLK);
            RST = 1;
            chk("midrst_pdata", p_data, 0);
            chk("midrst_flags", {data_valid, par_err, stp_err}, 0);
            chk("midrst_cnten", cnt_enable, 0);
         end
      join
      repeat (4) @(negedge CLK);
      chk("midrst_nodv", dv_cnt - c0, 0);
      model_pd = 8'h00;

      // back-to-back frames: second start already low in the IDLE cycle
      c0 = dv_cnt;
      send(6'd32, 0, 0, 8'h01, 0, 1, t0);
      send(6'd32, 0, 0, 8'hFE, 0, 1, t1);
      repeat (5) @(negedge CLK);
      chk("b2b_count", dv_cnt - c0, 2);
      if (dv_cnt - c0 == 2) begin
         chk("b2b_first", dv_q[dv_q.size()-2], 8'h01);
         chk("b2b_second", dv_q[dv_q.size()-1], 8'hFE);
         chk("b2b_cyc", last_dv_cyc, t1 + 1 + 320);
      end
      model_pd = 8'hFE;

      for (int k = 0; k < 40; k++) begin
         rp = 6'd8 << $urandom_range(0, 2);
         rpe = 1'($urandom_range(0, 1));
         rpt = 1'($urandom_range(0, 1));
         rd = 8'($urandom);
         rfl = rpe && ($urandom_range(0, 3) == 0);
         rsb = $urandom_range(0, 4) != 0;
         epe = rfl;
         ese = ~rsb;
         edv = rsb && !epe;
         if (edv) model_pd = rd;
         frame($sformatf("rnd%0d", k), rp, rpe, rpt, rd, rfl, rsb, edv, model_pd, epe, ese);
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the shared `edge_bit_counter` and turns the oversampled serial line into parallel bytes. It detects the start bit and majority-votes three mid-bit samples. It shifts eight data bits LSB-first, checks optional parity and the stop bit, and emits a one-cycle `data_valid` with `p_data`. It sits between the synchronized `rx_in` line and the RX FIFO/register interface, and drives the counter's `enable`.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame (only 8 is supported).
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `rx_in`  in  1  serial line, already synchronized upstream; idles high.
- `prescale`  in  6  oversampling ratio; legal values are 8, 16 and 32; must be held stable while not IDLE.
- `par_en`  in  1  enables the parity bit; sampled at IDLE→START.
- `par_typ`  in  1  parity type: 0 = even, 1 = odd; sampled at IDLE→START.
- `bit_cnt`  in  4  from `edge_bit_counter`.
- `edge_cnt`  in  6  from `edge_bit_counter`.
- `cnt_enable`  out  1  drives the counter's `enable`.
- `p_data`  out  8  received byte.
- `data_valid`  out  1  one-cycle strobe; `p_data` is valid in that cycle.
- `par_err`  out  1  parity mismatch on the last frame.
- `stp_err`  out  1  stop bit sampled low on the last frame.

## Operation
- **Reset values:** state IDLE; all outputs 0; shift register 0.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **`cnt_enable`** is 1 in every state except IDLE. It is decoded from the registered state (Moore), so the counter clears whenever the state is IDLE.
- **Mid-bit sampling:** `mid = prescale >> 1`. The sampler captures `rx_in` at `edge_cnt` = mid-1, mid and mid+1. The 2-of-3 majority result is registered at the mid+1 edge and stays valid until the end of the bit.
- **End of bit (`eob`):** `edge_cnt == prescale - 1`. Compute this with 6-bit arithmetic; there is no wrap for legal prescale values. All state decisions are taken at `eob`.
- **IDLE:** if `rx_in == 0`, go to START and latch `par_en`/`par_typ`. At the same time clear `par_err` and `stp_err`.
- **START** (`bit_cnt` 0): at `eob`, if the sampled bit is 0 go to DATA. Otherwise go to IDLE (glitch); this asserts no error and no `data_valid`.
- **DATA** (`bit_cnt` 1–8):
  - At each `eob`, shift the sampled bit in LSB-first (the first data bit ends in `p_data[0]`).
  - At the `eob` with `bit_cnt == 8`, go to PARITY if the latched `par_en` is 1, else to STOP.
- **PARITY** (`bit_cnt` 9): at `eob`, `par_err <= (^shift ^ sampled) != par_typ`, then go to STOP.
- **STOP** (`bit_cnt` 9 or 10): at `eob`:
  - `stp_err <= ~sampled`.
  - If `sampled == 1` and `par_err == 0`: `p_data <= shift` and `data_valid <= 1` for exactly one cycle.
  - Always go to IDLE.
- **`p_data`** holds its value until the next good frame. Error flags hold until the next IDLE→START.
- **Back-to-back frames:** the guaranteed IDLE cycle after STOP clears the counter. A start edge already low in that cycle is detected there, adding one cycle of skew, which mid-bit sampling tolerates.
- **Reset mid-frame:** at the next edge with `RST == 0`, go to IDLE with all outputs 0. No partial byte is emitted.

## Timing
- Let `rx_in` be first sampled low at edge T. START is entered at T+1, with `edge_cnt` 0 in that cycle.
- Each bit occupies `prescale` cycles.
- `data_valid` is high in cycle T+1+10·prescale (no parity) or T+1+11·prescale (parity).
- Error flags become visible in the same cycle as `data_valid` would.
- The earliest next start detection is that same cycle, which is the IDLE cycle.

## Structure
- **Package `uart_rx_pkg`:** `state_e` enum (IDLE, START, DATA, PARITY, STOP), the `DATA_WIDTH` constant, and the bit-index constants `START_BIT` = 0, `LAST_DATA_BIT` = 8 and `PARITY_BIT` = 9.
- **Sub-module `data_sampler`:** the three-sample majority voter. Inputs are `prescale`, `edge_cnt`, `rx_in` and `enable`; the output is `sampled_bit`.
- **In `uart_rx_ctrl` itself:** FSM, shift register and checkers.
- **`edge_bit_counter`** is instantiated beside this block at the next level up, not inside it.

## Test plan
- **Clean frame, no parity:** `prescale` = 8, `par_en` = 0, send 0xA5 → exactly one `data_valid` at T+81 with `p_data` = 0xA5, `par_err` = `stp_err` = 0.
- **Odd parity, correct bit:** `prescale` = 16, `par_en` = 1, `par_typ` = 1, send 0x3C with parity 1 → `data_valid` at T+177 with `p_data` = 0x3C.
- **Wrong parity bit:** same frame with parity 0 → `par_err` = 1 at T+177, no `data_valid`, and `p_data` keeps its previous value.
- **Stop-bit error:** `prescale` = 8, stop bit driven 0 → `stp_err` = 1 and no `data_valid`.
- **Start glitch:** `rx_in` low for only 2 cycles at `prescale` = 16 → return to IDLE at T+16 with `cnt_enable` = 0; the next valid frame (0x55) is received correctly.
- **Reset and back-to-back traffic:** pull `RST` low mid-DATA for one cycle → next edge is IDLE with all outputs 0. Then send 0x01 and 0xFE back-to-back at `prescale` = 32 → two `data_valid` strobes with `p_data` 0x01 then 0xFE.
